pipe_hazard_unit: RTL and testbench

Parametrised hazard-detection and forwarding controller for the pipelined RV32I core. It keeps a shadow pipeline of per-stage metadata (valid, rd, write-enable, load flag) for every stage past Decode. From that state it generates fetch/decode stalls, branch flushes, load-use bubbles and operand-forwarding selects. Pipeline depth, load-data stage and register-address width are parameters, so one block serves the 5-stage core and deeper variants.

---
 rtl/pipe_hazard_unit.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard detection / forwarding controller tracking per-stage metadata past Decode.
// Define HAZ_FWD_EN for forwarding with load-use bubbles; the default build is a pure interlock.
module pipe_hazard_unit #(
    parameter int unsigned RA_W       = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_ready,
    input  logic             d_valid,
    input  logic [RA_W-1:0]  d_rs1,
    input  logic [RA_W-1:0]  d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [RA_W-1:0]  d_rd,
    input  logic             d_we,
    input  logic             d_is_load,
    input  logic             br_taken,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [DEPTH-1:0] stage_valid
);

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rd;
        logic            we;
        logic            ld;
    } stage_t;

    stage_t [DEPTH-1:0] shd_q, shd_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic             match_a, match_b;
    logic             hit_a, hit_b;
    logic             ld_a, ld_b;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             haz;

    assign match_a = d_valid && d_use_rs1 && (d_rs1 != '0);
    assign match_b = d_valid && d_use_rs2 && (d_rs2 != '0);

    // Youngest producer search: scanning oldest to youngest lets the smallest k win.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        sel_a = '0;
        sel_b = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (match_a && shd_q[k].v && shd_q[k].we && (shd_q[k].rd == d_rs1)) begin
                hit_a = 1'b1;
                ld_a  = shd_q[k].ld;
                sel_a = SEL_W'(k + 1);
            end
            if (match_b && shd_q[k].v && shd_q[k].we && (shd_q[k].rd == d_rs2)) begin
                hit_b = 1'b1;
                ld_b  = shd_q[k].ld;
                sel_b = SEL_W'(k + 1);
            end
        end
    end

`ifdef HAZ_FWD_EN
    assign haz = (hit_a && ld_a && (32'(sel_a) < LOAD_STAGE)) ||
                 (hit_b && ld_b && (32'(sel_b) < LOAD_STAGE));
    assign fwd_sel_a = sel_a;
    assign fwd_sel_b = sel_b;
`else
    logic unused_fwd;
    assign haz        = hit_a || hit_b;
    assign fwd_sel_a  = '0;
    assign fwd_sel_b  = '0;
    assign unused_fwd = ^{sel_a, sel_b, ld_a, ld_b};
`endif

    // Control priority: memory freeze, then branch redirect, then data hazard.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!mem_ready) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
        end else if (br_taken) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (haz) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        shd_d = shd_q;
        if (mem_ready) begin
            for (int k = int'(DEPTH) - 1; k > 0; k--) begin
                shd_d[k] = shd_q[k-1];
            end
            if (flush_e) begin
                shd_d[0] = '0;
            end else begin
                shd_d[0].v  = d_valid;
                shd_d[0].rd = d_rd;
                shd_d[0].we = d_we;
                shd_d[0].ld = d_is_load;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shd_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            shd_q       <= shd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            stage_valid[k] = shd_q[k].v;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit (DEPTH=3, LOAD_STAGE=2, CNT_W=4); expectations follow HAZ_FWD_EN.
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ready, d_valid, d_use_rs1, d_use_rs2, d_we, d_is_load, br_taken;
    logic [4:0] d_rs1, d_rs2, d_rd;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic [3:0] stall_cnt;
    logic [2:0] stage_valid;

    typedef struct {
        string      nm;
        logic       sf, sd, fd, fe;
        logic [1:0] fa, fb;
        logic [3:0] cnt;
        logic [2:0] sv;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.RA_W(5), .DEPTH(3), .LOAD_STAGE(2), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ready  (mem_ready),
        .d_valid    (d_valid),
        .d_rs1      (d_rs1),
        .d_rs2      (d_rs2),
        .d_use_rs1  (d_use_rs1),
        .d_use_rs2  (d_use_rs2),
        .d_rd       (d_rd),
        .d_we       (d_we),
        .d_is_load  (d_is_load),
        .br_taken   (br_taken),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .stall_cnt  (stall_cnt),
        .stage_valid(stage_valid)
    );

    // Monitor: outputs settle by the falling edge; compare against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [15:0] act, req;
            e   = exp_q.pop_front();
            act = {stall_f, stall_d, flush_d, flush_e, fwd_sel_a, fwd_sel_b, stall_cnt, stage_valid};
            req = {e.sf, e.sd, e.fd, e.fe, e.fa, e.fb, e.cnt, e.sv};
            n_checks++;
            if (act === req) n_pass++;
            else $display("FAIL %s: got sf/sd/fd/fe=%b%b%b%b fa=%0d fb=%0d cnt=%0d sv=%b, want sf/sd/fd/fe=%b%b%b%b fa=%0d fb=%0d cnt=%0d sv=%b",
                          e.nm, stall_f, stall_d, flush_d, flush_e, fwd_sel_a, fwd_sel_b, stall_cnt, stage_valid,
                          e.sf, e.sd, e.fd, e.fe, e.fa, e.fb, e.cnt, e.sv);
        end
    end

    task automatic cyc(input string nm, input logic mr, br, dv,
                       input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, ld,
                       input logic stl, fd, fe, input logic [1:0] fa, fb,
                       input logic [3:0] cnt, input logic [2:0] sv);
        exp_t e;
        @(posedge clk);
        #1;
        mem_ready = mr; br_taken = br; d_valid = dv;
        d_rs1 = rs1; d_use_rs1 = u1; d_rs2 = rs2; d_use_rs2 = u2;
        d_rd = rd; d_we = we; d_is_load = ld;
        e.nm = nm; e.sf = stl; e.sd = stl; e.fd = fd; e.fe = fe;
        e.fa = fa; e.fb = fb; e.cnt = cnt; e.sv = sv;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        mem_ready = 1'b1; br_taken = 1'b0; d_valid = 1'b0;
        d_rs1 = '0; d_rs2 = '0; d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
        d_rd = '0; d_we = 1'b0; d_is_load = 1'b0;

        //  name          mr br dv rs1 u1 rs2 u2 rd we ld | stl fd fe fa fb cnt sv
        cyc("reset",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 3'b000);
        @(negedge clk); #1 rst = 1'b1;

`ifdef HAZ_FWD_EN
        cyc("alu_prod",    1, 0, 1, 0, 0, 0, 0, 5, 1, 0,    0, 0, 0, 0, 0, 0, 3'b000);
        cyc("fwd_a_s1",    1, 0, 1, 5, 1, 0, 0, 6, 1, 0,    0, 0, 0, 1, 0, 0, 3'b001);
        cyc("fwd_b_s2",    1, 0, 1, 6, 1, 5, 1, 0, 0, 0,    0, 0, 0, 1, 2, 0, 3'b011);
        cyc("fwd_b_s3",    1, 0, 1, 6, 1, 5, 1, 0, 0, 0,    0, 0, 0, 2, 3, 0, 3'b111);
        cyc("retired",     1, 0, 1, 5, 1, 6, 1, 7, 1, 1,    0, 0, 0, 0, 3, 0, 3'b111);
        cyc("load_use",    1, 0, 1, 0, 0, 7, 1, 8, 1, 0,    1, 0, 1, 0, 1, 0, 3'b111);
        cyc("load_fwd",    1, 0, 1, 0, 0, 7, 1, 8, 1, 0,    0, 0, 0, 0, 2, 1, 3'b110);
        cyc("x0_unused",   1, 0, 1, 0, 1, 7, 0, 0, 1, 0,    0, 0, 0, 0, 0, 1, 3'b101);
        cyc("x0_dest",     1, 0, 1, 0, 1, 8, 0, 9, 1, 1,    0, 0, 0, 0, 0, 1, 3'b011);
        cyc("br_over_lu",  1, 1, 1, 9, 1, 0, 0, 10, 1, 0,   0, 1, 1, 1, 0, 1, 3'b111);
        cyc("after_br",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 3'b110);
        cyc("freeze1",     0, 1, 1, 9, 1, 0, 0, 11, 1, 0,   1, 0, 0, 3, 0, 1, 3'b100);
        cyc("freeze2",     0, 1, 1, 9, 1, 0, 0, 11, 1, 0,   1, 0, 0, 3, 0, 2, 3'b100);
        cyc("freeze3",     0, 1, 1, 9, 1, 0, 0, 11, 1, 0,   1, 0, 0, 3, 0, 3, 3'b100);
        cyc("freeze_rel",  1, 1, 1, 9, 1, 0, 0, 11, 1, 0,   0, 1, 1, 3, 0, 4, 3'b100);
        cyc("post_flush",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 4, 3'b000);
        for (int i = 0; i < 13; i++) begin
            cyc("saturate",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, ((4 + i) > 15) ? 4'd15 : 4'(4 + i), 3'b000);
        end
`else
        cyc("il_prod",     1, 0, 1, 0, 0, 0, 0, 3, 1, 0,    0, 0, 0, 0, 0, 0, 3'b000);
        cyc("il_nop",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 3'b001);
        cyc("il_stall_s2", 1, 0, 1, 3, 1, 0, 0, 4, 1, 0,    1, 0, 1, 0, 0, 0, 3'b010);
        cyc("il_stall_s3", 1, 0, 1, 3, 1, 0, 0, 4, 1, 0,    1, 0, 1, 0, 0, 1, 3'b100);
        cyc("il_release",  1, 0, 1, 3, 1, 0, 0, 4, 1, 0,    0, 0, 0, 0, 0, 2, 3'b000);
        cyc("il_x0_unused",1, 0, 1, 0, 1, 4, 0, 0, 1, 0,    0, 0, 0, 0, 0, 2, 3'b001);
        cyc("il_stall_b",  1, 0, 1, 0, 1, 4, 1, 5, 1, 1,    1, 0, 1, 0, 0, 2, 3'b011);
        cyc("il_br",       1, 1, 1, 0, 1, 4, 1, 5, 1, 1,    0, 1, 1, 0, 0, 3, 3'b110);
        cyc("il_nop2",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 3, 3'b100);
        cyc("il_prod6",    1, 0, 1, 0, 0, 0, 0, 6, 1, 0,    0, 0, 0, 0, 0, 3, 3'b000);
        cyc("il_freeze1",  0, 1, 1, 6, 1, 0, 0, 7, 1, 0,    1, 0, 0, 0, 0, 3, 3'b001);
        cyc("il_freeze2",  0, 1, 1, 6, 1, 0, 0, 7, 1, 0,    1, 0, 0, 0, 0, 4, 3'b001);
        cyc("il_freeze3",  0, 1, 1, 6, 1, 0, 0, 7, 1, 0,    1, 0, 0, 0, 0, 5, 3'b001);
        cyc("il_frz_rel",  1, 1, 1, 6, 1, 0, 0, 7, 1, 0,    0, 1, 1, 0, 0, 6, 3'b001);
        cyc("il_after",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 6, 3'b010);
        for (int i = 0; i < 11; i++) begin
            cyc("saturate",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, ((6 + i) > 15) ? 4'd15 : 4'(6 + i), 3'b100);
        end
`endif
        // Reset lands in the middle of a stall and must wipe shadow and counter.
        @(negedge clk); #1 rst = 1'b0;
        cyc("rst_hold",    1, 0, 1, 13, 1, 0, 0, 13, 1, 0,  0, 0, 0, 0, 0, 0, 3'b000);
        @(negedge clk); #1 rst = 1'b1;
`ifdef HAZ_FWD_EN
        cyc("rst_fwd",     1, 0, 1, 13, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 3'b001);
`else
        cyc("rst_il",      1, 0, 1, 13, 1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 3'b001);
`endif

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
